// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the 300-baud UART receiver
package uart_pkg;

  localparam int CLKS_PER_BIT = 500;
  localparam int HALF_BIT     = 250;
  localparam int DATA_W       = 8;

  localparam logic PARITY_ODD  = 1'b0;
  localparam logic PARITY_EVEN = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  // True when data plus parity bit satisfies the selected parity mode.
  function automatic logic parity_ok(input logic [DATA_W-1:0] data,
                                     input logic par, input logic mode);
    return (^{data, par}) ^ (mode == PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_receive_baud_counter.sv
// rtl/uart_receive_baud_counter.sv - bit-period counter producing half- and full-bit ticks
module baud_counter #(
  parameter int CLKS_PER_BIT = 500,
  parameter int HALF_BIT     = 250
) (
  input  logic ref_clk_i,
  input  logic reset_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam int CNT_W = ($clog2(CLKS_PER_BIT) < 9) ? 9 : $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign half_tick_o = enable_i && (cnt_q == CNT_W'(HALF_BIT - 1));
  assign full_tick_o = enable_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = full_tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ref_clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - start/8N/parity/stop UART receiver sampled on ref_clk
module uart_receive #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int HALF_BIT     = uart_pkg::HALF_BIT
) (
  input  logic       ref_clk,
  input  logic       nreset,
  input  logic       serial_in,
  input  logic       parity_mode,
  input  logic       rx_done,
  output logic       receive,
  output logic [7:0] data_out
);

  import uart_pkg::*;

  logic              sync1_q, rx_s_q;
  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_ok_q, par_ok_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              recv_q, recv_d;
  logic              restart, enable, half_tick, full_tick, frame_ok;

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_baud_counter (
    .ref_clk_i   (ref_clk),
    .reset_i     (nreset),
    .restart_i   (restart),
    .enable_i    (enable),
    .half_tick_o (half_tick),
    .full_tick_o (full_tick)
  );

  assign receive  = recv_q;
  assign data_out = data_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    data_d    = data_q;
    restart   = 1'b0;
    frame_ok  = 1'b0;
    enable    = (state_q != IDLE) && (state_q != WAIT_IDLE);

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          restart   = 1'b1;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        // Re-phase the counter on the start-bit centre so data samples land mid-bit.
        if (half_tick) begin
          restart = 1'b1;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (full_tick) begin
          par_ok_d = parity_ok(shift_q, rx_s_q, parity_mode);
          state_d  = STOP;
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rx_s_q) begin
            frame_ok = par_ok_q;
            state_d  = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_ok) begin
      data_d = shift_q;
    end

    recv_d = recv_q;
    if (rx_done) begin
      recv_d = 1'b0;
    end
    if (frame_ok) begin
      recv_d = 1'b1;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (nreset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
      data_q    <= '0;
      recv_q    <= 1'b0;
    end else begin
      sync1_q   <= serial_in;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      data_q    <= data_d;
      recv_q    <= recv_d;
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - scoreboard bench for uart_receive with a frame-level reference model
module tb_uart_receive;

  localparam int CPB     = 500;
  localparam int LATENCY = 5253;

  logic       ref_clk = 1'b0;
  logic       nreset;
  logic       serial_in;
  logic       parity_mode;
  logic       rx_done;
  logic       receive;
  logic [7:0] data_out;

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic        prev_rx = 1'b0;

  uart_receive dut (
    .ref_clk     (ref_clk),
    .nreset      (nreset),
    .serial_in   (serial_in),
    .parity_mode (parity_mode),
    .rx_done     (rx_done),
    .receive     (receive),
    .data_out    (data_out)
  );

  always #5 ref_clk = ~ref_clk;
  always @(posedge ref_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its cycle budget (cyc=%0d)", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is accepted iff the stop bit is high and the count of
  // ones across data and parity is odd (odd mode) or even (even mode).
  function automatic bit frame_valid(input logic [7:0] d, input logic p,
                                     input logic stop, input logic mode);
    int ones;
    ones = $countones(d) + int'(p);
    return stop && ((ones % 2 == 1) == (mode == 1'b0));
  endfunction

  function automatic logic good_parity(input logic [7:0] d, input logic mode);
    return ($countones(d) % 2 == 0) ? (mode == 1'b0) : (mode == 1'b1);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input logic mode, input bit coinc, input int hold_low);
    exp_t e;
    parity_mode = mode;
    if (frame_valid(d, p, stop, mode)) begin
      e.data = d;
      e.due  = cyc + LATENCY;
      sb.push_back(e);
    end
    if (coinc) begin
      fork
        begin
          tick(LATENCY - 1);
          rx_done = 1'b1;
          tick(1);
          rx_done = 1'b0;
        end
      join_none
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
    if (hold_low > 0) tick(hold_low);
    serial_in = 1'b1;
    tick(50);
  endtask

  task automatic ack(input string name);
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    check(name, receive, 1'b0);
  endtask

  always @(negedge ref_clk) begin
    if (receive === 1'b1 && prev_rx !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_receive: got data %0h with no frame expected", data_out);
      end else begin
        mon_e = sb.pop_front();
        check("mon_data", data_out, mon_e.data);
        checks++;
        if (cyc + 2 < mon_e.due || cyc > mon_e.due + 2) begin
          errors++;
          $display("FAIL mon_latency: got cycle %0d expected %0d", cyc, mon_e.due);
        end
      end
    end
    prev_rx = receive;
  end

  initial begin
    logic [7:0] d;
    logic       p, s, m;
    serial_in   = 1'b1;
    rx_done     = 1'b0;
    parity_mode = 1'b0;
    nreset      = 1'b1;
    tick(5);
    nreset = 1'b0;
    check("reset_receive", receive, 1'b0);
    check("reset_data", data_out, 8'h00);
    tick(20);

    send_frame(8'hCD, 1'b0, 1'b1, 1'b0, 0, 0);
    check("odd_cd_receive", receive, 1'b1);
    check("odd_cd_data", data_out, 8'hCD);
    ack("odd_cd_clear");

    send_frame(8'hCD, 1'b1, 1'b1, 1'b0, 0, 0);
    check("bad_parity_receive", receive, 1'b0);
    check("bad_parity_hold", data_out, 8'hCD);

    send_frame(8'hCD, 1'b0, 1'b0, 1'b0, 0, 600);
    check("framing_receive", receive, 1'b0);
    check("framing_hold", data_out, 8'hCD);

    send_frame(8'h5A, good_parity(8'h5A, 1'b0), 1'b1, 1'b0, 0, 0);
    check("after_framing_data", data_out, 8'h5A);
    ack("after_framing_clear");

    send_frame(8'h47, 1'b1, 1'b1, 1'b0, 0, 0);
    check("odd_47_data", data_out, 8'h47);
    ack("odd_47_clear");

    send_frame(8'hCD, 1'b1, 1'b1, 1'b1, 0, 0);
    check("even_cd_data", data_out, 8'hCD);
    ack("even_cd_clear");

    send_frame(8'hCD, 1'b0, 1'b1, 1'b1, 0, 0);
    check("even_reject_receive", receive, 1'b0);

    send_frame(8'h3C, good_parity(8'h3C, 1'b0), 1'b1, 1'b0, 0, 0);
    serial_in = 1'b0;
    tick(CPB * 3);
    nreset    = 1'b1;
    serial_in = 1'b1;
    tick(2);
    nreset = 1'b0;
    check("midframe_reset_receive", receive, 1'b0);
    check("midframe_reset_data", data_out, 8'h00);
    tick(50);

    serial_in = 1'b0;
    tick(100);
    serial_in = 1'b1;
    tick(600);
    check("glitch_receive", receive, 1'b0);

    send_frame(8'h96, good_parity(8'h96, 1'b1), 1'b1, 1'b1, 1, 0);
    check("coinc_set_wins", receive, 1'b1);
    check("coinc_data", data_out, 8'h96);
    ack("coinc_clear");

    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      m = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, m, 0, 0);
      if (frame_valid(d, p, s, m)) begin
        check("rand_receive", receive, 1'b1);
        ack("rand_clear");
      end else begin
        check("rand_reject", receive, 1'b0);
      end
    end

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
